// File: rtl/step_sequence_ctrl_if.sv
// Command channel from the UI/button decoder into the step sequencer run controller.
// Handshake completes on a cycle where cmd_valid and cmd_ready are both high.
interface step_sequence_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [8:0] cmd_data;

  modport master (output cmd_valid, cmd_op, cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_data, output cmd_ready);
endinterface

// File: rtl/step_sequence_ctrl.sv
// Run controller for the stepped sequencer: step period timing, run/pause/stop
// lifecycle and speed changes that only land on step boundaries while running.
module step_sequence_ctrl #(
  parameter int TICKS_PER_UNIT = 1000000,
  parameter int NUM_STEPS      = 12,
  parameter int STEP_W         = 4,
  parameter int CNT_W          = 29,
  parameter int DEFAULT_SPEED  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  step_sequence_ctrl_if.slave cmd,
  output logic [STEP_W-1:0]   step_out,
  output logic                step_tick,
  output logic                done,
  output logic                busy,
  output logic                paused,
  output logic [8:0]          speed_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;

  localparam logic [1:0] OP_SET   = 2'd0;
  localparam logic [1:0] OP_START = 2'd1;
  localparam logic [1:0] OP_PAUSE = 2'd2;
  localparam logic [1:0] OP_STOP  = 2'd3;

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period;
  logic [8:0]       speed_eff;
  logic [8:0]       pend_speed;
  logic             pend_valid;
  logic             loop;
  logic             acc;
  logic             boundary;
  logic             last;

  // Speed 0 is stored as-is but timed like speed 1.
  assign speed_eff = (speed_out == 9'd0) ? 9'd1 : speed_out;
  assign period    = CNT_W'(speed_eff) * CNT_W'(TICKS_PER_UNIT);
  // >= rather than == so a period shrunk under a frozen count cannot overrun.
  assign boundary  = (cnt >= period - CNT_W'(1));
  assign last      = (step_out == LAST_STEP);

  assign cmd.cmd_ready = ~pend_valid;
  assign acc           = cmd.cmd_valid & ~pend_valid;
  assign busy          = (state != S_IDLE);
  assign paused        = (state == S_PAUSE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      step_out   <= '0;
      speed_out  <= 9'(DEFAULT_SPEED);
      pend_speed <= '0;
      pend_valid <= 1'b0;
      loop       <= 1'b0;
      step_tick  <= 1'b0;
      done       <= 1'b0;
    end else begin
      step_tick <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt      <= '0;
          step_out <= '0;
          if (acc) begin
            if (cmd.cmd_op == OP_SET) speed_out <= cmd.cmd_data;
            if (cmd.cmd_op == OP_START) begin
              state <= S_RUN;
              loop  <= cmd.cmd_data[0];
            end
          end
        end
        S_RUN: begin
          if (acc && cmd.cmd_op == OP_PAUSE) begin
            state <= S_PAUSE;
          end else if (acc && cmd.cmd_op == OP_STOP) begin
            state    <= S_IDLE;
            cnt      <= '0;
            step_out <= '0;
          end else begin
            if (acc && cmd.cmd_op == OP_SET) begin
              pend_speed <= cmd.cmd_data;
              pend_valid <= 1'b1;
            end
            if (boundary) begin
              cnt       <= '0;
              step_tick <= 1'b1;
              if (last && !loop) begin
                done     <= 1'b1;
                state    <= S_IDLE;
                step_out <= '0;
                // Leaving RUN: a speed arriving on this edge must not stay pending.
                if (acc && cmd.cmd_op == OP_SET) begin
                  speed_out  <= cmd.cmd_data;
                  pend_valid <= 1'b0;
                end
              end else begin
                step_out <= last ? '0 : step_out + STEP_W'(1);
              end
              if (pend_valid) begin
                speed_out  <= pend_speed;
                pend_valid <= 1'b0;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        S_PAUSE: begin
          if (acc) begin
            case (cmd.cmd_op)
              OP_SET:   speed_out <= cmd.cmd_data;
              OP_PAUSE: state     <= S_RUN;
              OP_STOP: begin
                state    <= S_IDLE;
                cnt      <= '0;
                step_out <= '0;
              end
              default: ;
            endcase
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_step_sequence_ctrl.sv
// Scoreboard bench for step_sequence_ctrl: expected ticks are queued as commands
// are issued and retired by a monitor whenever step_tick pulses.
module tb_step_sequence_ctrl;
  localparam int TPU = 4;
  localparam int NS  = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] step_out;
  logic       step_tick, done, busy, paused;
  logic [8:0] speed_out;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  typedef struct {int cyc; int step; int dn;} tick_t;
  tick_t exp_q[$];

  step_sequence_ctrl_if bus();

  step_sequence_ctrl #(
    .TICKS_PER_UNIT(TPU), .NUM_STEPS(NS), .STEP_W(4), .CNT_W(29), .DEFAULT_SPEED(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd(bus),
    .step_out(step_out), .step_tick(step_tick), .done(done),
    .busy(busy), .paused(paused), .speed_out(speed_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_tick(input int c, input int s, input int d);
    tick_t t;
    t.cyc = c; t.step = s; t.dn = d;
    exp_q.push_back(t);
  endtask

  // Returns the cycle number of the accepting edge.
  task automatic send(input logic [1:0] op, input int data, output int acc_cyc);
    int n;
    n = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = 9'(data);
    while (!bus.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("send_timeout", n, 0);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic to_cyc(input int target);
    do @(negedge clk); while (cyc < target);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (step_tick) begin
      if (exp_q.size() == 0) begin
        chk("extra_tick", cyc, -1);
      end else begin
        tick_t t;
        t = exp_q.pop_front();
        chk("tick_cyc", cyc, t.cyc);
        chk("tick_step", int'(step_out), t.step);
        chk("tick_done", int'(done), t.dn);
      end
    end else if (done) begin
      chk("stray_done", 1, 0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e, a, r, c, k;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.cmd_data  = 9'd0;
    repeat (3) @(negedge clk);
    chk("rst_step", int'(step_out), 0);
    chk("rst_speed", int'(speed_out), 1);
    chk("rst_ready", int'(bus.cmd_ready), 1);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_tick", int'(step_tick), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_paused", int'(paused), 0);

    // Loop at speed 3: period 12, wrap on the 12th tick.
    send(2'd0, 3, a);
    chk("idle_set_speed", int'(speed_out), 3);
    send(2'd1, 1, e);
    chk("run_busy", int'(busy), 1);
    for (k = 1; k <= 13; k++) push_tick(e + 12 * k, k % NS, 0);
    wait_drain(300);
    send(2'd3, 0, a);
    @(negedge clk);
    chk("stop_busy", int'(busy), 0);

    // One-shot at speed 1.
    send(2'd0, 1, a);
    send(2'd1, 0, e);
    for (k = 1; k <= NS; k++) push_tick(e + 4 * k, (k == NS) ? 0 : k, (k == NS) ? 1 : 0);
    wait_drain(100);
    idle(20);
    @(negedge clk);
    chk("oneshot_busy", int'(busy), 0);
    chk("oneshot_step", int'(step_out), 0);

    // Speed change 3 -> 1 mid-period lands on the boundary.
    send(2'd0, 3, a);
    send(2'd1, 1, e);
    push_tick(e + 12, 1, 0);
    idle(4);
    send(2'd0, 1, a);
    @(negedge clk);
    chk("pend_ready", int'(bus.cmd_ready), 0);
    chk("pend_speed_hold", int'(speed_out), 3);
    for (k = 1; k <= 4; k++) push_tick(e + 12 + 4 * k, 1 + k, 0);
    to_cyc(e + 11);
    chk("pend_ready_late", int'(bus.cmd_ready), 0);
    to_cyc(e + 12);
    chk("pend_ready_clear", int'(bus.cmd_ready), 1);
    chk("pend_applied", int'(speed_out), 1);
    wait_drain(100);
    send(2'd3, 0, a);

    // Pause at cnt=5 for 20 cycles at speed 3.
    send(2'd0, 3, a);
    send(2'd1, 1, e);
    idle(5);
    send(2'd2, 0, a);
    c = a - 1 - e;
    @(negedge clk);
    chk("pause_flag", int'(paused), 1);
    idle(20);
    send(2'd2, 0, r);
    push_tick(r + 12 - c, 1, 0);
    push_tick(r + 24 - c, 2, 0);
    @(negedge clk);
    chk("resume_flag", int'(paused), 0);
    wait_drain(100);
    send(2'd3, 0, a);

    // Pause at speed 5 with cnt=10, drop to speed 1, resume.
    send(2'd0, 5, a);
    send(2'd1, 1, e);
    idle(10);
    send(2'd2, 0, a);
    send(2'd0, 1, a);
    chk("pause_set_speed", int'(speed_out), 1);
    send(2'd2, 0, r);
    push_tick(r + 1, 1, 0);
    push_tick(r + 5, 2, 0);
    push_tick(r + 9, 3, 0);
    wait_drain(100);
    send(2'd3, 0, a);

    // STOP landing exactly on a boundary edge suppresses the tick.
    send(2'd0, 1, a);
    send(2'd1, 1, e);
    push_tick(e + 4, 1, 0);
    idle(7);
    send(2'd3, 0, a);
    chk("stop_on_boundary_cyc", a, e + 8);
    @(negedge clk);
    chk("stop_bnd_step", int'(step_out), 0);
    chk("stop_bnd_busy", int'(busy), 0);
    idle(10);
    chk("stop_bnd_queue", exp_q.size(), 0);

    // Async reset while a speed change is pending.
    send(2'd0, 3, a);
    send(2'd1, 1, e);
    idle(2);
    send(2'd0, 7, a);
    @(negedge clk);
    chk("rst_pend_ready_before", int'(bus.cmd_ready), 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_speed", int'(speed_out), 1);
    chk("rst_async_ready", int'(bus.cmd_ready), 1);
    chk("rst_async_busy", int'(busy), 0);
    chk("rst_async_step", int'(step_out), 0);
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    idle(30);
    @(negedge clk);
    chk("post_rst_speed", int'(speed_out), 1);
    chk("final_queue", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
